// File: rtl/sram_controller_if.sv
// CPU-side load/store handshake plus the 16-bit asynchronous SRAM pin bundle.
// The controller uses the slave view; the CPU and SRAM drive the master side.
interface sram_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two timed 16-bit SRAM accesses (low half, then high half)
// and stalls the pipeline via ready until the whole word has completed.
module sram_controller #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter logic [31:0] MEM_BASE      = 32'd1024
) (
   input logic          clk,
   input logic          rst,
   sram_controller_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        is_wr_q;
   logic [16:0] idx_q;
   logic [15:0] wdata_hi_q;
   logic [31:0] read_data_q;
   logic [17:0] sram_addr_q;
   logic [15:0] dq_out_q;
   logic        dq_oe_q;
   logic        we_n_q;
   logic [16:0] req_idx;
   logic        last;

   // Word index wraps modulo 2^32 so addresses below MEM_BASE alias high SRAM words.
   function automatic logic [16:0] word_index(input logic [31:0] addr);
      logic [31:0] offset;
      offset = addr - MEM_BASE;
      return offset[18:2];
   endfunction

   assign req_idx = word_index(bus.address);
   assign cnt_d   = cnt_q + 4'd1;
   assign last    = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         idx_q       <= '0;
         wdata_hi_q  <= '0;
         read_data_q <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.wr_en || bus.rd_en) begin
                  state_q     <= LOW;
                  cnt_q       <= '0;
                  is_wr_q     <= bus.wr_en;
                  idx_q       <= req_idx;
                  wdata_hi_q  <= bus.write_data[31:16];
                  sram_addr_q <= {req_idx, 1'b0};
                  dq_out_q    <= bus.wr_en ? bus.write_data[15:0] : 16'h0000;
                  dq_oe_q     <= bus.wr_en;
                  we_n_q      <= ~bus.wr_en;
               end
            end
            LOW: begin
               if (last) begin
                  state_q     <= HIGH;
                  cnt_q       <= '0;
                  sram_addr_q <= {idx_q, 1'b1};
                  dq_out_q    <= is_wr_q ? wdata_hi_q : 16'h0000;
                  we_n_q      <= ~is_wr_q;
                  if (!is_wr_q) read_data_q[15:0] <= bus.sram_dq_in;
               end else begin
                  cnt_q  <= cnt_d;
                  // WE# rises for the final cycle of a phase so data is held past the strobe.
                  we_n_q <= ~is_wr_q || (cnt_d == LAST);
               end
            end
            HIGH: begin
               if (last) begin
                  state_q     <= DONE;
                  cnt_q       <= '0;
                  sram_addr_q <= '0;
                  dq_out_q    <= '0;
                  dq_oe_q     <= 1'b0;
                  we_n_q      <= 1'b1;
                  if (!is_wr_q) read_data_q[31:16] <= bus.sram_dq_in;
               end else begin
                  cnt_q  <= cnt_d;
                  we_n_q <= ~is_wr_q || (cnt_d == LAST);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready       = (state_q == DONE) ||
                            ((state_q == IDLE) && !bus.wr_en && !bus.rd_en);
   assign bus.read_data   = read_data_q;
   assign bus.sram_addr   = sram_addr_q;
   assign bus.sram_dq_out = dq_out_q;
   assign bus.sram_dq_oe  = dq_oe_q;
   assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed and randomized load/store traffic on two controllers (2 and 3 cycles per half),
// each attached to a behavioural SRAM; results checked against a transaction-level model.
module tb_sram_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_controller_if if_a ();
   sram_controller_if if_b ();

   sram_controller #(.ACCESS_CYCLES(2), .MEM_BASE(32'd1024)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   sram_controller #(.ACCESS_CYCLES(3), .MEM_BASE(32'd1024)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   // Behavioural SRAMs: asynchronous read, write on every cycle with OE and WE# low.
   bit [15:0] mem_a [0:262143];
   bit [15:0] mem_b [0:262143];
   int        wcnt_a = 0;

   assign if_a.sram_dq_in = mem_a[if_a.sram_addr];
   assign if_b.sram_dq_in = mem_b[if_b.sram_addr];

   always @(posedge clk) begin
      if (if_a.sram_dq_oe && !if_a.sram_we_n) begin
         mem_a[if_a.sram_addr] <= if_a.sram_dq_out;
         wcnt_a <= wcnt_a + 1;
      end
      if (if_b.sram_dq_oe && !if_b.sram_we_n) mem_b[if_b.sram_addr] <= if_b.sram_dq_out;
   end

   // Transaction-level reference: halfword store keyed by (dut, halfword address).
   logic [15:0] ref_mem [int];
   logic [31:0] rd_ref [2];

   int vectors     = 0;
   int miscompares = 0;

   logic        o_ready, o_oe, o_we_n;
   logic [17:0] o_addr;
   logic [15:0] o_dq;
   logic [31:0] o_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int b, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] wd);
      if (b == 0) begin
         if_a.wr_en = wr; if_a.rd_en = rd; if_a.address = addr; if_a.write_data = wd;
      end else begin
         if_b.wr_en = wr; if_b.rd_en = rd; if_b.address = addr; if_b.write_data = wd;
      end
   endtask

   task automatic snap(input int b);
      if (b == 0) begin
         o_ready = if_a.ready; o_oe = if_a.sram_dq_oe; o_we_n = if_a.sram_we_n;
         o_addr = if_a.sram_addr; o_dq = if_a.sram_dq_out; o_rdata = if_a.read_data;
      end else begin
         o_ready = if_b.ready; o_oe = if_b.sram_dq_oe; o_we_n = if_b.sram_we_n;
         o_addr = if_b.sram_addr; o_dq = if_b.sram_dq_out; o_rdata = if_b.read_data;
      end
   endtask

   function automatic logic [15:0] ref_rd(input int key);
      return ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
   endfunction

   // One full access starting in IDLE; hold keeps the enables asserted through DONE.
   task automatic xact(input int b, input bit wr, input bit rd,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold);
      int          ac;
      int          phase;
      int          pos;
      int          key;
      logic [31:0] off;
      logic [16:0] idx;
      bit          is_wr;
      ac    = (b == 0) ? 2 : 3;
      off   = addr - 32'd1024;
      idx   = off[18:2];
      is_wr = wr;
      key   = b * 262144 + int'({idx, 1'b0});
      if (is_wr) begin
         ref_mem[key]     = wd[15:0];
         ref_mem[key + 1] = wd[31:16];
      end else begin
         rd_ref[b] = {ref_rd(key + 1), ref_rd(key)};
      end
      for (int k = 0; k <= 2 * ac + 1; k++) begin
         @(negedge clk);
         if (k == 0) drive(b, wr, rd, addr, wd);
         else if (k == 1 && !hold) drive(b, 1'b0, 1'b0, $urandom, $urandom);
         #1;
         snap(b);
         if (k == 0) begin
            chk("req_ready", o_ready, 0);
            chk("req_addr", o_addr, 0);
            chk("req_we_n", o_we_n, 1);
            chk("req_oe", o_oe, 0);
         end else if (k <= 2 * ac) begin
            phase = (k - 1) / ac;
            pos   = (k - 1) % ac;
            chk("busy_ready", o_ready, 0);
            chk("busy_addr", o_addr, {14'd0, idx, phase[0]});
            chk("busy_oe", o_oe, is_wr);
            chk("busy_we_n", o_we_n, is_wr ? (pos == ac - 1) : 1'b1);
            if (is_wr) chk("busy_dq", o_dq, (phase == 1) ? wd[31:16] : wd[15:0]);
         end else begin
            chk("done_ready", o_ready, 1);
            chk("done_addr", o_addr, 0);
            chk("done_we_n", o_we_n, 1);
            chk("done_oe", o_oe, 0);
            chk("done_dq", o_dq, 0);
            chk("done_rdata", o_rdata, rd_ref[b]);
         end
      end
      $display("xact dut%0d %s addr=%h wdata=%h hold=%0d read_data=%h",
               b, is_wr ? "store" : "load", addr, wd, hold, o_rdata);
   endtask

   initial begin
      logic [31:0] a;
      logic [16:0] ridx;
      int          op;
      int          wsnap;

      rd_ref[0] = '0;
      rd_ref[1] = '0;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      for (int b = 0; b < 2; b++) begin
         snap(b);
         chk("rst_ready", o_ready, 1);
         chk("rst_we_n", o_we_n, 1);
         chk("rst_oe", o_oe, 0);
         chk("rst_addr", o_addr, 0);
         chk("rst_dq", o_dq, 0);
         chk("rst_rdata", o_rdata, 0);
      end
      rst = 1'b0;

      // Basic store/load, idle ready, back-to-back held enables, both-enables write.
      xact(0, 1, 0, 32'd1032, 32'hDEADBEEF, 0);
      xact(0, 0, 1, 32'd1032, 32'h0, 0);
      @(negedge clk); #1; snap(0);
      chk("idle_ready", o_ready, 1);
      xact(0, 1, 0, 32'd1044, 32'h12345678, 1);
      xact(0, 0, 1, 32'd1044, 32'h0, 0);
      xact(0, 1, 1, 32'd1024, 32'hCAFEF00D, 0);

      for (int n = 0; n < 24; n++) begin
         op = $urandom_range(0, 2);
         if ($urandom_range(0, 4) == 0) a = 32'd1024 - 32'($urandom_range(1, 4) * 4);
         else a = 32'd1024 + 32'($urandom_range(0, 15) * 4);
         a = a + 32'($urandom_range(0, 3));
         xact(0, op != 1, op != 0, a, $urandom, $urandom_range(0, 1) == 1);
      end
      drive(0, 0, 0, 0, 0);

      // Reset during the high-half phase of a store.
      a = 32'd1424;
      ridx = 17'd100;
      @(negedge clk); drive(0, 1, 0, a, 32'hA5A55A5A);
      @(negedge clk); drive(0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk); #1; snap(0);
      chk("abort_in_high", o_addr, {14'd0, ridx, 1'b1});
      rst = 1'b1;
      @(negedge clk); #1; snap(0);
      rd_ref[0] = '0;
      chk("abort_ready_in_rst", o_ready, 1);
      chk("abort_we_n", o_we_n, 1);
      chk("abort_oe", o_oe, 0);
      chk("abort_addr", o_addr, 0);
      chk("abort_rdata", o_rdata, 0);
      rst = 1'b0;
      wsnap = wcnt_a;
      repeat (6) @(negedge clk);
      #1; snap(0);
      chk("abort_no_writes", wcnt_a, wsnap);
      chk("abort_idle_ready", o_ready, 1);

      // Three cycles per half: store/load latency and WE# width.
      xact(1, 1, 0, 32'd1032, 32'hDEADBEEF, 0);
      xact(1, 0, 1, 32'd1032, 32'h0, 0);
      xact(1, 1, 0, 32'd1020, 32'h0BADC0DE, 1);
      xact(1, 0, 1, 32'd1020, 32'h0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: ACCESS_CYCLES, default 2, cycles per 16-bit half access; legal range 2..15.
REQ-002 Parameter: MEM_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-003 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 wr_en  in  1  store request from EXE/MEM stage.
REQ-005 rd_en  in  1  load request from EXE/MEM stage.
REQ-006 address  in  32  byte address; ALU result of LDR/STR.
REQ-007 write_data  in  32  store data.
REQ-008 read_data  out  32  load result, registered.
REQ-009 ready  out  1  1 = access complete or no access; 0 = freeze pipeline.
REQ-010 sram_addr  out  18  SRAM halfword address.
REQ-011 sram_dq_out  out  16  SRAM write data.
REQ-012 sram_dq_oe  out  1  1 = sram_dq_out drives the bus.
REQ-013 sram_dq_in  in  16  SRAM read data.
REQ-014 sram_we_n  out  1  active-low SRAM write enable.

Function
REQ-015 States: IDLE, LOW, HIGH, DONE; 4-bit phase counter cnt.
REQ-016 IDLE with (wr_en|rd_en)=1 -> LOW, cnt=0; otherwise stay IDLE.
REQ-017 Request latched at IDLE exit: op (write if wr_en=1, else read), address, write_data; both enables set -> write, read_data unchanged.
REQ-018 LOW: cnt increments each cycle; when cnt=ACCESS_CYCLES-1 -> HIGH, cnt=0.
REQ-019 HIGH: same counting; when cnt=ACCESS_CYCLES-1 -> DONE.
REQ-020 DONE: one cycle, then IDLE unconditionally.
REQ-021 Word index = (latched address - MEM_BASE) modulo 2^32, bits [18:2]; address bits [1:0] ignored.
REQ-022 sram_addr = {word index, 0} in LOW, {word index, 1} in HIGH, 0 in IDLE/DONE.
REQ-023 Write, LOW: sram_dq_out = write_data[15:0]; HIGH: write_data[31:16]; sram_dq_oe=1 throughout both phases.
REQ-024 Write: sram_we_n=0 in every LOW/HIGH cycle except the last cycle of each phase (cnt=ACCESS_CYCLES-1), where it is 1.
REQ-025 Read: sram_dq_oe=0, sram_we_n=1; on last LOW cycle read_data[15:0] <= sram_dq_in; on last HIGH cycle read_data[31:16] <= sram_dq_in.
REQ-026 IDLE/DONE: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-027 ready = 1 in DONE; 1 in IDLE when wr_en=rd_en=0; 0 otherwise (combinational from state and enables).
REQ-028 Latency: request in IDLE at cycle 0 -> ready=1 in cycle 2*ACCESS_CYCLES+1 (cycle 5 at default); ready=0 for cycles 0..2*ACCESS_CYCLES.
REQ-029 Enables held through DONE are not re-sampled there; a new access starts only from IDLE (back-to-back gap: one IDLE cycle, ready=0 there).
REQ-030 Enable deassertion or input change during LOW/HIGH is ignored; the latched access completes.
REQ-031 read_data holds its value between loads and across writes.

Reset
REQ-032 rst=1 at a rising edge -> state=IDLE, cnt=0, read_data=0, latched registers=0, regardless of current state.
REQ-033 Reset mid-access aborts the access; in the cycle after reset: sram_we_n=1, sram_dq_oe=0, sram_addr=0.
REQ-034 While rst=1, ready follows REQ-027 in IDLE.

Verification
REQ-035 Store: address=1032, write_data=0xDEADBEEF, wr_en=1 -> sram_addr 4 then 5; dq_out 0xBEEF then 0xDEAD; sram_we_n low one cycle per phase; ready=1 in cycle 5.
REQ-036 Load: rd_en=1, address=1032, sram model returns 0xBEEF at addr 4 and 0xDEAD at addr 5 -> read_data=0xDEADBEEF with ready=1 in cycle 5.
REQ-037 Back-to-back: store then load to the same address with enables held -> second access starts after one IDLE cycle; read_data equals stored value.
REQ-038 Both enables=1, address=1024 -> write to sram_addr 0/1, read_data unchanged.
REQ-039 rst asserted in HIGH phase of a write -> next cycle IDLE, we_n=1, oe=0, read_data=0; no further SRAM writes.
REQ-040 ACCESS_CYCLES=3 -> ready=1 in cycle 7; we_n low two cycles per phase.
